// File: rtl/pong_uart_pkg.sv
// Shared constants for the UART paddle command path: command bytes, case-fold mask, RX states.
package pong_uart_pkg;

  localparam logic [7:0] CMD_P1_UP = 8'h77;  // 'w'
  localparam logic [7:0] CMD_P1_DN = 8'h73;  // 's'
  localparam logic [7:0] CMD_P2_UP = 8'h69;  // 'i'
  localparam logic [7:0] CMD_P2_DN = 8'h6B;  // 'k'
  localparam logic [7:0] CMD_START = 8'h20;  // ' '
  localparam logic [7:0] CMD_STOP  = 8'h78;  // 'x'
  localparam logic [7:0] CASE_FOLD = 8'h20;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = RX_IDLE,
    S_START = RX_START,
    S_DATA  = RX_DATA,
    S_STOP  = RX_STOP
  } rx_state_t;

  // Maps ASCII upper-case letters onto lower case; only meaningful for letter commands.
  function automatic logic [7:0] fold_case(input logic [7:0] b);
    return b | CASE_FOLD;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with input synchronizer; pulses o_RxValid/o_FrameErr the cycle after the stop sample.
// Optional saturating frame-error counter under `UART_PADDLE_ERR_CNT_EN.
module uart_rx_core
  import pong_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_UART_RX,
  output logic [7:0] o_RxByte,
  output logic       o_RxValid,
  output logic       o_FrameErr
`ifdef UART_PADDLE_ERR_CNT_EN
  ,
  output logic [7:0] o_ErrCount
`endif
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  rx_state_t              state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2:0]             bit_q, bit_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             byte_q, byte_d;
  logic                   valid_d, ferr_d;

  assign rx_s     = sync_q[SYNC_STAGES-1];
  assign o_RxByte = byte_q;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      sync_q     <= '1;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      byte_q     <= '0;
      o_RxValid  <= 1'b0;
      o_FrameErr <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], i_UART_RX};
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      byte_q     <= byte_d;
      o_RxValid  <= valid_d;
      o_FrameErr <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      S_START: begin
        // A line that is high again at mid start bit was a glitch.
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        // Sampling mid stop bit leaves half a bit to catch a back-to-back start edge.
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (rx_s) begin
            byte_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef UART_PADDLE_ERR_CNT_EN
  logic [7:0] err_q;

  always_ff @(posedge i_Clk) begin
    if (i_Reset)                          err_q <= 8'h00;
    else if (o_FrameErr && err_q != 8'hFF) err_q <= err_q + 8'd1;
  end

  assign o_ErrCount = err_q;
`endif

endmodule

// File: rtl/uart_paddle_cmd.sv
// UART RX to pong paddle/start controls: ASCII decoder plus four reloadable hold timers.
// Paddles/start follow o_RxValid by one cycle; `UART_PADDLE_ERR_CNT_EN adds o_ErrCount.
module uart_paddle_cmd
  import pong_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int HOLD_CLKS    = 2500000,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_UART_RX,
  output logic       o_Paddle_P1_Up,
  output logic       o_Paddle_P1_Down,
  output logic       o_Paddle_P2_Up,
  output logic       o_Paddle_P2_Down,
  output logic       o_StartGame,
  output logic [7:0] o_RxByte,
  output logic       o_RxValid,
  output logic       o_FrameErr
`ifdef UART_PADDLE_ERR_CNT_EN
  ,
  output logic [7:0] o_ErrCount
`endif
);

  localparam int TW = $clog2(HOLD_CLKS + 1);
  localparam logic [TW-1:0] HOLD = TW'(HOLD_CLKS);

  uart_rx_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .SYNC_STAGES  (SYNC_STAGES)
  ) u_rx (
    .i_Clk      (i_Clk),
    .i_Reset    (i_Reset),
    .i_UART_RX  (i_UART_RX),
    .o_RxByte   (o_RxByte),
    .o_RxValid  (o_RxValid),
    .o_FrameErr (o_FrameErr)
`ifdef UART_PADDLE_ERR_CNT_EN
    ,
    .o_ErrCount (o_ErrCount)
`endif
  );

  logic [7:0]    cmd;
  logic          ld_p1u, ld_p1d, ld_p2u, ld_p2d, clr_all, start_d;
  logic [TW-1:0] t_p1u, t_p1d, t_p2u, t_p2d;

  assign cmd = fold_case(o_RxByte);

  always_comb begin
    ld_p1u  = 1'b0;
    ld_p1d  = 1'b0;
    ld_p2u  = 1'b0;
    ld_p2d  = 1'b0;
    clr_all = 1'b0;
    // Space is matched unfolded: folding would also alias 0x00 onto it.
    start_d = o_RxValid && (o_RxByte == CMD_START);
    if (o_RxValid) begin
      case (cmd)
        CMD_P1_UP: ld_p1u  = 1'b1;
        CMD_P1_DN: ld_p1d  = 1'b1;
        CMD_P2_UP: ld_p2u  = 1'b1;
        CMD_P2_DN: ld_p2d  = 1'b1;
        CMD_STOP:  clr_all = 1'b1;
        default: ;
      endcase
    end
  end

  function automatic logic [TW-1:0] tnext(input logic [TW-1:0] t, input logic load,
                                          input logic clr);
    if (load)         return HOLD;
    else if (clr)     return '0;
    else if (t != '0) return t - TW'(1);
    else              return t;
  endfunction

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      t_p1u       <= '0;
      t_p1d       <= '0;
      t_p2u       <= '0;
      t_p2d       <= '0;
      o_StartGame <= 1'b0;
    end else begin
      t_p1u       <= tnext(t_p1u, ld_p1u, ld_p1d | clr_all);
      t_p1d       <= tnext(t_p1d, ld_p1d, ld_p1u | clr_all);
      t_p2u       <= tnext(t_p2u, ld_p2u, ld_p2d | clr_all);
      t_p2d       <= tnext(t_p2d, ld_p2d, ld_p2u | clr_all);
      o_StartGame <= start_d;
    end
  end

  assign o_Paddle_P1_Up   = (t_p1u != '0);
  assign o_Paddle_P1_Down = (t_p1d != '0);
  assign o_Paddle_P2_Up   = (t_p2u != '0);
  assign o_Paddle_P2_Down = (t_p2d != '0);

endmodule
